// File: rtl/hvmux_pkg.sv
// Shared HVMUX definitions: default geometry and the sequencer FSM state type.
package hvmux_pkg;

  localparam int SWITCH_N_DEF = 16;
  localparam int DEPTH_DEF    = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    ARMED
  } hvmux_seq_state_t;

endpackage

// File: rtl/hvmux_seq_ram.sv
// DEPTH x SWITCH_N switch-pattern table: synchronous write, asynchronous read
// so the sequencer sees the current contents at the moment it issues a pattern.
module hvmux_seq_ram
  import hvmux_pkg::*;
#(
  parameter  int SWITCH_N = SWITCH_N_DEF,
  parameter  int DEPTH    = DEPTH_DEF,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [SWITCH_N-1:0] wdata,
  input  logic [AW-1:0]       raddr,
  output logic [SWITCH_N-1:0] rdata
);

  logic [SWITCH_N-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto distributed RAM; entries are
  // undefined until software writes them.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hvmux_seq.sv
// HVMUX pattern sequencer: pushes table patterns to the SPI controller on start/step,
// gated on controller busy. Define HVMUX_SEQ_LOOP_EN to wrap at seq_last instead of ending.
module hvmux_seq
  import hvmux_pkg::*;
#(
  parameter  int SWITCH_N = SWITCH_N_DEF,
  parameter  int DEPTH    = DEPTH_DEF,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [SWITCH_N-1:0] cfg_wdata,
  input  logic [AW-1:0]       seq_last,
  input  logic                start,
  input  logic                step,
  input  logic                abort,
  output logic [SWITCH_N-1:0] mux_din,
  output logic                mux_dvalid,
  input  logic                mux_busy,
  output logic                active,
  output logic                ready,
  output logic [AW-1:0]       seq_idx,
  output logic                done,
  output logic                err_overrun
);

  hvmux_seq_state_t    state, state_nxt;
  logic [SWITCH_N-1:0] rd_data;
  logic [SWITCH_N-1:0] din_nxt;
  logic [AW-1:0]       idx_nxt;
  logic                dvalid_nxt, active_nxt, ready_nxt, done_nxt, err_nxt;

  hvmux_seq_ram #(
    .SWITCH_N (SWITCH_N),
    .DEPTH    (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (seq_idx),
    .rdata (rd_data)
  );

  // NOTE: non-blocking assignments on every register so all of them update from
  // the same pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mux_din     <= '0;
      mux_dvalid  <= 1'b0;
      active      <= 1'b0;
      ready       <= 1'b0;
      seq_idx     <= '0;
      done        <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state       <= state_nxt;
      mux_din     <= din_nxt;
      mux_dvalid  <= dvalid_nxt;
      active      <= active_nxt;
      ready       <= ready_nxt;
      seq_idx     <= idx_nxt;
      done        <= done_nxt;
      err_overrun <= err_nxt;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would infer a latch.
  always_comb begin
    state_nxt  = state;
    din_nxt    = mux_din;
    dvalid_nxt = 1'b0;
    active_nxt = active;
    ready_nxt  = ready;
    idx_nxt    = seq_idx;
    done_nxt   = 1'b0;
    err_nxt    = err_overrun;

    if (abort) begin
      state_nxt  = IDLE;
      active_nxt = 1'b0;
      ready_nxt  = 1'b0;
    end else begin
      // A step that arrives before the current pattern is latched is dropped.
      if (step && active && (state != ARMED)) err_nxt = 1'b1;

      unique case (state)
        IDLE: begin
          if (start && !mux_busy) begin
            idx_nxt    = '0;
            err_nxt    = 1'b0;
            active_nxt = 1'b1;
            state_nxt  = ISSUE;
          end
        end
        ISSUE: begin
          din_nxt    = rd_data;
          dvalid_nxt = 1'b1;
          state_nxt  = WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (mux_busy) state_nxt = WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!mux_busy) begin
            ready_nxt = 1'b1;
            state_nxt = ARMED;
          end
        end
        ARMED: begin
          if (step) begin
            ready_nxt = 1'b0;
            if (seq_idx != seq_last) begin
              idx_nxt   = seq_idx + 1'b1;
              state_nxt = ISSUE;
            end else begin
              done_nxt = 1'b1;
`ifdef HVMUX_SEQ_LOOP_EN
              idx_nxt   = '0;
              state_nxt = ISSUE;
`else
              active_nxt = 1'b0;
              state_nxt  = IDLE;
`endif
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
